accumulate: RTL and testbench
=============================

Name: accumulate

Overview:
- Pipeline stage directly upstream of the block-RAM write stage.
- Buffers incoming lane vectors in a small FIFO.
- Sums `num_accum` consecutive vectors lane-wise, producing partial sums across input channels.
- Forwards each finished sum downstream over the valid/avail handshake; repeats for `num_outputs` results per configuration.

Parameters:
- GROUP_SIZE, 4, number of parallel lanes per vector
- DATA_WIDTH, 8, bits per lane, input and output (unsigned)
- LOG_MAX_ACCUM, 8, width of num_accum
- LOG_MAX_OUTPUTS, 16, width of num_outputs

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- configure  in  1  one-cycle configure strobe
- num_accum  in  LOG_MAX_ACCUM  vectors summed per output (0 treated as 1)
- num_outputs  in  LOG_MAX_OUTPUTS  outputs produced before returning to idle
- data_in  in  GROUP_SIZE*DATA_WIDTH  input vector, lane i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- valid_in  in  1  data_in valid; written to FIFO unconditionally
- avail_out  out  1  upstream may send (FIFO not full and not almost_full)
- data_out  out  GROUP_SIZE*DATA_WIDTH  accumulated vector, same lane packing
- valid_out  out  1  data_out valid, single-cycle pulse per output
- avail_in  in  1  downstream can accept this cycle

Behaviour:
- Reset state (rst==0 at posedge): FSM=IDLE; acc, counters and data_out all 0; valid_out=0; FIFO emptied, so avail_out=1 the following cycle.
- Input FIFO: 4 slots. almost_full when 3 occupied. The almost_full margin absorbs one cycle of upstream avail lag. Write while full is a protocol error; data is dropped.
- Pop from FIFO only in ACCUM with FIFO non-empty. One pop per cycle max. Simultaneous push and pop allowed.
- FSM states: IDLE, ACCUM, EMIT.
- Any state, configure=1 (and rst=1):
  - latch num_accum (0→1) and num_outputs;
  - clear acc and count;
  - go to ACCUM, or stay IDLE if num_outputs==0;
  - FIFO contents are kept;
  - configure takes priority over any pop or emit in the same cycle.
- IDLE: no pops; inputs still buffered until FIFO fills.
- ACCUM, each pop:
  - first pop of an output loads acc = data; later pops do acc = acc + data, lane-wise, mod 2^DATA_WIDTH (wrap), no cross-lane carry;
  - count increments;
  - on the pop that makes count == num_accum: go to EMIT, register the final sum into data_out.
- EMIT:
  - if avail_in==1: valid_out=1 for that cycle, decrement outputs-remaining; if it reaches 0 go to IDLE, else ACCUM with count=0.
  - if avail_in==0: hold data_out, valid_out=0, no pops.
- valid_out is 0 in every state other than the accepting EMIT cycle. data_out holds its last value otherwise.
- Latency:
  - last contributing vector written at cycle t, FIFO empty before → popped at t+1 → valid_out at t+2 earliest (avail_in high);
  - throughput: one output per num_accum+1 cycles.
- Reset mid-operation: abandons the partial sum and flushes the FIFO; no valid_out after reset until reconfigured.

Optional Feature:
- ACCUMULATE_SATURATE_EN defined: lane addition saturates at 2^DATA_WIDTH-1 instead of wrapping (e.g. 0xF0+0x20 = 0xFF).
- Undefined: modulo wrap (0xF0+0x20 = 0x10).
- No other behaviour changes.

Test Plan:
- Basic sum:
  - Stimulus: configure num_accum=3, num_outputs=1; send lanes {1,2,3,4}, {1,1,1,1}, {10,0,0,5}, avail_in=1.
  - Response: one valid_out with {12,3,4,10}, then IDLE.
- Back-pressure:
  - Stimulus: num_accum=2, num_outputs=2; avail_in=0 for 10 cycles after the first sum.
  - Response: data_out held; avail_out falls after FIFO reaches 3 entries; no data lost; two outputs once avail_in=1.
- Wrap vs saturate:
  - Stimulus: num_accum=2; lanes 0xF0 and 0x20.
  - Response: output 0x10 without ACCUMULATE_SATURATE_EN, 0xFF with it.
- Boundary config:
  - Stimulus 1: num_accum=0, num_outputs=3, vectors {5,6,7,8}, {9,9,9,9}, {0,0,0,1}.
  - Response 1: three outputs equal to the inputs (pass-through).
  - Stimulus 2: num_outputs=0.
  - Response 2: no valid_out ever.
- Reconfigure and reset mid-run:
  - Stimulus: configure mid-accumulation with a new num_accum=1.
  - Response: partial sum discarded; next output equals the next FIFO vector.
  - Stimulus: rst=0 for one cycle mid-run.
  - Response: valid_out=0, data_out=0, avail_out=1 next cycle.

Source files
------------

// File: rtl/accumulate.sv
// accumulate: FIFO-buffered lane-wise vector accumulator feeding the block-RAM write stage.
// Define ACCUMULATE_SATURATE_EN to make lane additions saturate instead of wrapping.
module accumulate #(
  parameter int GROUP_SIZE      = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int LOG_MAX_ACCUM   = 8,
  parameter int LOG_MAX_OUTPUTS = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             configure,
  input  logic [LOG_MAX_ACCUM-1:0]         num_accum,
  input  logic [LOG_MAX_OUTPUTS-1:0]       num_outputs,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in,
  input  logic                             valid_in,
  output logic                             avail_out,
  output logic [GROUP_SIZE*DATA_WIDTH-1:0] data_out,
  output logic                             valid_out,
  input  logic                             avail_in
);

  localparam int VW         = GROUP_SIZE * DATA_WIDTH;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t                     state;
  logic [VW-1:0]              acc;
  logic [LOG_MAX_ACCUM-1:0]   count;
  logic [LOG_MAX_ACCUM-1:0]   count_next;
  logic [LOG_MAX_ACCUM-1:0]   accum_target;
  logic [LOG_MAX_OUTPUTS-1:0] outputs_left;

  logic [VW-1:0] fifo_mem [FIFO_DEPTH];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    fill;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [VW-1:0] head;
  logic [VW-1:0] acc_sum;

  function automatic logic [VW-1:0] lane_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
`ifdef ACCUMULATE_SATURATE_EN
    logic [DATA_WIDTH:0] s;
    r = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      s = {1'b0, a[i*DATA_WIDTH +: DATA_WIDTH]} + {1'b0, b[i*DATA_WIDTH +: DATA_WIDTH]};
      r[i*DATA_WIDTH +: DATA_WIDTH] = s[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : s[DATA_WIDTH-1:0];
    end
`else
    r = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      r[i*DATA_WIDTH +: DATA_WIDTH] = a[i*DATA_WIDTH +: DATA_WIDTH] + b[i*DATA_WIDTH +: DATA_WIDTH];
    end
`endif
    return r;
  endfunction

  // The almost-full margin leaves one slot for a vector already in flight upstream.
  assign fifo_empty = (fill == 3'd0);
  assign fifo_full  = (fill == 3'd4);
  assign avail_out  = (fill < 3'd3);
  assign push       = valid_in && !fifo_full;
  assign pop        = (state == ACCUM) && !fifo_empty && !configure;
  assign head       = fifo_mem[rd_ptr];
  assign count_next = count + LOG_MAX_ACCUM'(1);
  assign acc_sum    = (count == '0) ? head : lane_add(acc, head);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   fill <= fill + 3'd1;
        2'b01:   fill <= fill - 3'd1;
        default: fill <= fill;
      endcase
    end
  end

  // Configure overrides any pop or emit in the same cycle; buffered vectors survive it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      acc          <= '0;
      count        <= '0;
      accum_target <= '0;
      outputs_left <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (configure) begin
        accum_target <= (num_accum == '0) ? LOG_MAX_ACCUM'(1) : num_accum;
        outputs_left <= num_outputs;
        acc          <= '0;
        count        <= '0;
        state        <= (num_outputs == '0) ? IDLE : ACCUM;
      end else begin
        unique case (state)
          IDLE: begin
          end
          ACCUM: begin
            if (pop) begin
              acc   <= acc_sum;
              count <= count_next;
              if (count_next == accum_target) begin
                data_out <= acc_sum;
                state    <= EMIT;
              end
            end
          end
          EMIT: begin
            if (avail_in) begin
              valid_out    <= 1'b1;
              outputs_left <= outputs_left - LOG_MAX_OUTPUTS'(1);
              count        <= '0;
              state        <= (outputs_left == LOG_MAX_OUTPUTS'(1)) ? IDLE : ACCUM;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_accumulate.sv
// tb_accumulate: table vectors, hand-written corner sequences and randomized runs
// checked against a lane-sum reference model.
module tb_accumulate;

  logic        clk = 1'b0;
  logic        rst;
  logic        configure;
  logic [7:0]  num_accum;
  logic [15:0] num_outputs;
  logic [31:0] data_in;
  logic        valid_in;
  logic        avail_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        avail_in;

  int applied = 0;
  int miscompares = 0;

  logic [31:0] got[$];
  logic [31:0] send_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] hist[$];

  typedef struct packed {
    logic [7:0]        na;
    logic [15:0]       no;
    logic [3:0]        nvec;
    logic [2:0][31:0]  vin;
    logic [3:0]        nexp;
    logic [2:0][31:0]  vexp;
  } vec_t;

  vec_t tbl[4];

  always #5 clk = ~clk;

  accumulate dut (
    .clk(clk), .rst(rst), .configure(configure), .num_accum(num_accum),
    .num_outputs(num_outputs), .data_in(data_in), .valid_in(valid_in),
    .avail_out(avail_out), .data_out(data_out), .valid_out(valid_out),
    .avail_in(avail_in)
  );

  always @(negedge clk) begin
    if (valid_out === 1'b1) got.push_back(data_out);
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0; configure = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic doConfigure(input logic [7:0] na, input logic [15:0] no);
    @(negedge clk);
    configure = 1'b1; num_accum = na; num_outputs = no;
    @(negedge clk);
    configure = 1'b0;
  endtask

  // avail_mode: 0 = downstream always ready, 1 = random back-pressure, 2 = held off
  task automatic applyStimulus(input int nexp, input int max_cycles, input int avail_mode);
    int cyc;
    cyc = 0;
    while (cyc < max_cycles && !(send_q.size() == 0 && got.size() >= nexp)) begin
      @(negedge clk);
      avail_in = (avail_mode == 2) ? 1'b0 :
                 (avail_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (send_q.size() != 0 && avail_out) begin
        valid_in = 1'b1;
        data_in  = send_q.pop_front();
      end else begin
        valid_in = 1'b0;
      end
      cyc++;
    end
    @(negedge clk);
    valid_in = 1'b0;
    if (avail_mode != 2) avail_in = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic compareOutputs(input string name);
    checkOutput({name, " count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      checkOutput(name, (i < got.size()) ? got[i] : 32'hxxxxxxxx, exp_q[i]);
  endtask

  // Lane-wise sum of hist[start .. start+n-1] using plain integer arithmetic.
  function automatic logic [31:0] refSum(input int start, input int n);
    logic [31:0] r;
    int s;
    r = '0;
    for (int lane = 0; lane < 4; lane++) begin
      s = 0;
      for (int k = 0; k < n; k++) s += int'(hist[start+k][lane*8 +: 8]);
`ifdef ACCUMULATE_SATURATE_EN
      if (s > 255) s = 255;
`else
      s = s % 256;
`endif
      r[lane*8 +: 8] = s[7:0];
    end
    return r;
  endfunction

  initial begin
    int na, no, nae;
    logic [31:0] v;
    logic [31:0] x;

    rst = 1'b0; configure = 1'b0; valid_in = 1'b0; avail_in = 1'b1;
    data_in = '0; num_accum = '0; num_outputs = '0;

    tbl[0] = '0; tbl[0].na = 8'd3; tbl[0].no = 16'd1; tbl[0].nvec = 4'd3;
    tbl[0].vin[0] = 32'h04030201; tbl[0].vin[1] = 32'h01010101; tbl[0].vin[2] = 32'h0500000A;
    tbl[0].nexp = 4'd1; tbl[0].vexp[0] = 32'h0A04030C;
    tbl[1] = '0; tbl[1].na = 8'd0; tbl[1].no = 16'd3; tbl[1].nvec = 4'd3;
    tbl[1].vin[0] = 32'h08070605; tbl[1].vin[1] = 32'h09090909; tbl[1].vin[2] = 32'h01000000;
    tbl[1].nexp = 4'd3;
    tbl[1].vexp[0] = 32'h08070605; tbl[1].vexp[1] = 32'h09090909; tbl[1].vexp[2] = 32'h01000000;
    tbl[2] = '0; tbl[2].na = 8'd2; tbl[2].no = 16'd1; tbl[2].nvec = 4'd2;
    tbl[2].vin[0] = 32'hFF8001F0; tbl[2].vin[1] = 32'h01800220; tbl[2].nexp = 4'd1;
`ifdef ACCUMULATE_SATURATE_EN
    tbl[2].vexp[0] = 32'hFFFF03FF;
`else
    tbl[2].vexp[0] = 32'h00000310;
`endif
    tbl[3] = '0; tbl[3].na = 8'd1; tbl[3].no = 16'd0; tbl[3].nvec = 4'd2;
    tbl[3].vin[0] = 32'h11111111; tbl[3].vin[1] = 32'h22222222; tbl[3].nexp = 4'd0;

    doReset();
    checkOutput("reset valid_out", {31'b0, valid_out}, 32'd0);
    checkOutput("reset data_out", data_out, 32'd0);
    checkOutput("reset avail_out", {31'b0, avail_out}, 32'd1);

    for (int e = 0; e < 4; e++) begin
      doReset();
      doConfigure(tbl[e].na, tbl[e].no);
      got.delete(); send_q.delete(); exp_q.delete();
      for (int k = 0; k < int'(tbl[e].nvec); k++) send_q.push_back(tbl[e].vin[k]);
      for (int k = 0; k < int'(tbl[e].nexp); k++) exp_q.push_back(tbl[e].vexp[k]);
      applyStimulus(int'(tbl[e].nexp), 60, 0);
      compareOutputs($sformatf("table[%0d]", e));
    end

    // First-result latency: pushed at edge t, valid_out visible after edge t+2.
    doReset();
    doConfigure(8'd1, 16'd1);
    x = 32'h5A3C1E0F;
    avail_in = 1'b1; valid_in = 1'b1; data_in = x;
    @(negedge clk); valid_in = 1'b0;
    @(negedge clk);
    checkOutput("latency early valid_out", {31'b0, valid_out}, 32'd0);
    @(negedge clk);
    checkOutput("latency valid_out", {31'b0, valid_out}, 32'd1);
    checkOutput("latency data_out", data_out, x);

    // Back-pressure: first sum stalls in EMIT while the FIFO fills to three.
    doReset();
    doConfigure(8'd2, 16'd2);
    got.delete(); send_q.delete(); exp_q.delete(); hist.delete();
    for (int k = 0; k < 5; k++) begin
      v = 32'h10204080 + 32'h01010101 * k[31:0];
      hist.push_back(v); send_q.push_back(v);
    end
    applyStimulus(0, 40, 2);
    repeat (4) @(negedge clk);
    checkOutput("backpressure no output", got.size(), 32'd0);
    checkOutput("backpressure held data_out", data_out, refSum(0, 2));
    checkOutput("backpressure avail_out low", {31'b0, avail_out}, 32'd0);
    exp_q.push_back(refSum(0, 2)); exp_q.push_back(refSum(2, 2));
    applyStimulus(2, 40, 0);
    compareOutputs("backpressure");
    checkOutput("backpressure avail_out recovers", {31'b0, avail_out}, 32'd1);

    // Reconfigure mid-accumulation drops the partial sum.
    doReset();
    doConfigure(8'd3, 16'd1);
    got.delete(); send_q.delete(); exp_q.delete();
    send_q.push_back(32'h01020304); send_q.push_back(32'h10203040);
    applyStimulus(0, 20, 0);
    checkOutput("reconfig no early output", got.size(), 32'd0);
    doConfigure(8'd1, 16'd1);
    send_q.push_back(32'hCAFE0123);
    exp_q.push_back(32'hCAFE0123);
    applyStimulus(1, 30, 0);
    compareOutputs("reconfig");

    // Reset mid-run with a result held in EMIT and nothing reconfigured afterwards.
    doReset();
    doConfigure(8'd1, 16'd3);
    got.delete(); send_q.delete(); exp_q.delete();
    send_q.push_back(32'h0BADF00D); exp_q.push_back(32'h0BADF00D);
    applyStimulus(1, 30, 0);
    compareOutputs("midreset first");
    send_q.push_back(32'h7E7E7E7E);
    applyStimulus(0, 20, 2);
    doReset();
    checkOutput("midreset valid_out", {31'b0, valid_out}, 32'd0);
    checkOutput("midreset data_out", data_out, 32'd0);
    checkOutput("midreset avail_out", {31'b0, avail_out}, 32'd1);
    got.delete(); avail_in = 1'b1;
    send_q.push_back(32'h11223344); send_q.push_back(32'h55667788);
    applyStimulus(0, 20, 0);
    checkOutput("midreset no output", got.size(), 32'd0);

    // Randomized configurations and data with random downstream back-pressure.
    for (int it = 0; it < 25; it++) begin
      na  = $urandom_range(0, 4);
      no  = $urandom_range(1, 4);
      nae = (na == 0) ? 1 : na;
      doReset();
      doConfigure(na[7:0], no[15:0]);
      got.delete(); send_q.delete(); exp_q.delete(); hist.delete();
      for (int k = 0; k < nae * no; k++) begin
        v = $urandom;
        hist.push_back(v); send_q.push_back(v);
      end
      for (int o = 0; o < no; o++) exp_q.push_back(refSum(o * nae, nae));
      applyStimulus(no, 300, 1);
      compareOutputs($sformatf("random[%0d] na=%0d no=%0d", it, na, no));
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
